oob_signaler: RTL

- Physical-layer OOB engine between the OOB link-bring-up state machine and the transceiver.
- TX side: turns one-cycle COMRESET/COMWAKE strobes into six ALIGN bursts separated by electrical-idle gaps, then pulses completion.
- RX side: times the transceiver's electrical-idle indication and produces level COMINIT and COMWAKE detect flags.
- Clock is the 32-bit transceiver user clock, 75 MHz nominal (13.33 ns).

---
 rtl/oob_signaler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/oob_signaler.sv
// OOB signalling engine: COMRESET/COMWAKE burst generator on TX and
// COMINIT/COMWAKE gap-timing detector on RX.
module oob_signaler #(
    parameter int BURST_CYCLES     = 8,
    parameter int BURST_COUNT      = 6,
    parameter int INIT_IDLE_CYCLES = 24,
    parameter int WAKE_IDLE_CYCLES = 8,
    parameter int INIT_GAP_MIN     = 23,
    parameter int INIT_GAP_MAX     = 25,
    parameter int WAKE_GAP_MIN     = 7,
    parameter int WAKE_GAP_MAX     = 9,
    parameter int RX_BURST_MIN     = 2,
    parameter int RX_BURST_MAX     = 12,
    parameter int DETECT_COUNT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_comm_reset,
    input  logic        tx_comm_wake,
    output logic        tx_oob_complete,
    output logic        tx_busy,
    output logic [31:0] oob_tx_dout,
    output logic        oob_tx_is_k,
    output logic        oob_tx_elec_idle,
    input  logic        rx_is_elec_idle,
    output logic        comm_init_detect,
    output logic        comm_wake_detect
);

    localparam int CW = 8;
    localparam int SW = $clog2(DETECT_COUNT + 1);
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_BURST,
        TX_GAP,
        TX_DONE
    } tx_state_t;

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] gap;
    logic [3:0]    burst_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= TX_IDLE;
            cnt              <= '0;
            gap              <= '0;
            burst_cnt        <= '0;
            tx_busy          <= 1'b0;
            tx_oob_complete  <= 1'b0;
            oob_tx_dout      <= '0;
            oob_tx_is_k      <= 1'b0;
            oob_tx_elec_idle <= 1'b1;
        end else begin
            tx_oob_complete <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (tx_comm_reset || tx_comm_wake) begin
                        gap <= tx_comm_reset ? CW'(INIT_IDLE_CYCLES)
                                             : CW'(WAKE_IDLE_CYCLES);
                        state            <= TX_BURST;
                        cnt              <= '0;
                        burst_cnt        <= '0;
                        tx_busy          <= 1'b1;
                        oob_tx_dout      <= ALIGN;
                        oob_tx_is_k      <= 1'b1;
                        oob_tx_elec_idle <= 1'b0;
                    end
                end
                TX_BURST: begin
                    if (cnt == CW'(BURST_CYCLES - 1)) begin
                        state            <= TX_GAP;
                        cnt              <= '0;
                        oob_tx_dout      <= '0;
                        oob_tx_is_k      <= 1'b0;
                        oob_tx_elec_idle <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (cnt == gap - 1'b1) begin
                        cnt       <= '0;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == 4'(BURST_COUNT - 1)) begin
                            state           <= TX_DONE;
                            tx_busy         <= 1'b0;
                            tx_oob_complete <= 1'b1;
                        end else begin
                            state            <= TX_BURST;
                            oob_tx_dout      <= ALIGN;
                            oob_tx_is_k      <= 1'b1;
                            oob_tx_elec_idle <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DONE: state <= TX_IDLE;
                default: state <= TX_IDLE;
            endcase
        end
    end

    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] run_cnt;
    logic          prev_idle;
    logic [SW-1:0] init_seq;
    logic [SW-1:0] wake_seq;

    // run_cnt holds the last burst length through the following gap
    logic burst_ok, init_gap, wake_gap, run_long;
    logic init_clr, wake_clr, init_set, wake_set, gap_end;

    always_comb begin
        burst_ok = (run_cnt >= CW'(RX_BURST_MIN)) &&
                   (run_cnt <= CW'(RX_BURST_MAX));
        init_gap = (idle_cnt >= CW'(INIT_GAP_MIN)) &&
                   (idle_cnt <= CW'(INIT_GAP_MAX));
        wake_gap = (idle_cnt >= CW'(WAKE_GAP_MIN)) &&
                   (idle_cnt <= CW'(WAKE_GAP_MAX));
        run_long = run_cnt > CW'(RX_BURST_MAX);
        gap_end  = prev_idle && !rx_is_elec_idle;
        init_clr = run_long || (idle_cnt > CW'(INIT_GAP_MAX));
        wake_clr = run_long || (idle_cnt > CW'(WAKE_GAP_MAX));
        init_set = !init_clr && (init_seq == SW'(DETECT_COUNT));
        wake_set = !wake_clr && (wake_seq == SW'(DETECT_COUNT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt         <= '0;
            run_cnt          <= '0;
            prev_idle        <= 1'b0;
            init_seq         <= '0;
            wake_seq         <= '0;
            comm_init_detect <= 1'b0;
            comm_wake_detect <= 1'b0;
        end else begin
            prev_idle <= rx_is_elec_idle;
            if (rx_is_elec_idle) begin
                if (!prev_idle)
                    idle_cnt <= CW'(1);
                else if (idle_cnt != '1)
                    idle_cnt <= idle_cnt + 1'b1;
            end else begin
                if (prev_idle)
                    run_cnt <= CW'(1);
                else if (run_cnt != '1)
                    run_cnt <= run_cnt + 1'b1;
            end

            if (run_long) begin
                init_seq <= '0;
                wake_seq <= '0;
            end else if (gap_end) begin
                if (burst_ok && init_gap) begin
                    if (init_seq != SW'(DETECT_COUNT))
                        init_seq <= init_seq + 1'b1;
                    wake_seq <= '0;
                end else if (burst_ok && wake_gap) begin
                    if (wake_seq != SW'(DETECT_COUNT))
                        wake_seq <= wake_seq + 1'b1;
                    init_seq <= '0;
                end else begin
                    init_seq <= '0;
                    wake_seq <= '0;
                end
            end

            comm_init_detect <= init_set ||
                (comm_init_detect && !init_clr && !wake_set);
            comm_wake_detect <= wake_set ||
                (comm_wake_detect && !wake_clr && !init_set);
        end
    end

endmodule
